turn_signal_ctrl: RTL and testbench
===================================

Name: turn_signal_ctrl

Overview:
Sequencing and arbitration controller in front of the tail-light FSM. It accepts left, right and hazard requests and grants exactly one mode at a time. It drives the FSM's L/R inputs and generates a prescaled one-cycle step pulse that advances the light pattern. Each granted sequence runs for a whole pattern (SEQ_LEN steps) before any other mode is granted; hazard preemption is the only exception.

Parameters:
PRESCALE, 4, clock cycles per step pulse (must be >= 2)
SEQ_LEN, 4, step pulses per complete light sequence (must be >= 2)
CW, $clog2(SEQ_LEN), width of step_cnt

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (reset==0 clears all state on the next rising clk)
left_req  input  1  left turn request, level-sensitive
right_req  input  1  right turn request, level-sensitive
haz_req  input  1  hazard request, level-sensitive
L  output  1  left drive to light FSM
R  output  1  right drive to light FSM
step  output  1  one-cycle advance pulse to light FSM
busy  output  1  high whenever state != IDLE
step_cnt  output  CW  steps completed in the current sequence

Behaviour:
- States: IDLE, LEFT, RIGHT, HAZ. Outputs are registered or decoded from state only (Moore); no combinational path from inputs to outputs.
- Reset (reset==0 at an edge): state=IDLE, prescaler=0, step_cnt=0, L=R=step=busy=0. This takes effect from any state mid-sequence, and no completion step is emitted.
- Decode: L=1 in LEFT or HAZ; R=1 in RIGHT or HAZ; busy=1 in LEFT, RIGHT or HAZ.
- Arbitration is evaluated in IDLE and at sequence completion. Priority order:
  - haz_req, or left_req and right_req together -> HAZ
  - else left_req -> LEFT
  - else right_req -> RIGHT
  - else IDLE
- Grant latency: a request sampled at edge n puts the block in the new state at edge n; the outputs reflect it in cycle n+1. Entering a state clears the prescaler and step_cnt to 0.
- Prescaler: in an active state it counts 0..PRESCALE-1 and wraps. step=1 for exactly the cycle in which the prescaler is PRESCALE-1, so the first step comes PRESCALE cycles after entry.
- On each step, step_cnt increments.
- Completion: a step with step_cnt==SEQ_LEN-1. At that edge step_cnt wraps to 0, the prescaler stays at 0, and arbitration is re-run:
  - the same request still held -> the same state repeats back-to-back
  - a different request held -> direct switch to it with no IDLE cycle
  - no request -> IDLE
- Lockout: while LEFT or RIGHT is active, opposite-direction requests and request drops are ignored until completion. A 1-cycle request pulse therefore produces exactly one full sequence.
- Sequence length: one full sequence is PRESCALE*SEQ_LEN cycles with L/R held constant.
- In IDLE: step=0, and prescaler and step_cnt are held at 0.

Optional Feature:
HAZ_PREEMPT_EN
- Defined: haz_req asserted in LEFT or RIGHT forces HAZ at the next edge, regardless of step_cnt. The prescaler and step_cnt clear, and no step is emitted on the preempting edge. HAZ itself is never preempted.
- Undefined: haz_req gets no special treatment mid-sequence. It is honoured only at completion, via normal arbitration.

Test Plan (PRESCALE=4, SEQ_LEN=4):
1. reset=0 for 2 cycles with all requests high, then release -> L=R=step=busy=0 and step_cnt=0 while reset=0; HAZ is entered the cycle after release.
2. left_req pulsed for 1 cycle -> L=1, R=0, busy=1 for exactly 16 cycles; step high on cycles 4, 8, 12, 16 after entry; step_cnt goes 0,1,2,3 then 0; returns to IDLE.
3. right_req held continuously for 40 cycles -> RIGHT sequences repeat back-to-back with no IDLE gap and one step every 4 cycles; IDLE after the sequence in progress at release completes.
4. During LEFT at step_cnt=1, right_req pulsed, then held from step_cnt=3 -> LEFT completes unaffected; at completion the block switches directly to RIGHT with no idle cycle.
5. left_req and right_req asserted in the same IDLE cycle -> HAZ with L=R=1 for 16 cycles.
6. During LEFT at step_cnt=2, haz_req asserted:
   - with HAZ_PREEMPT_EN -> HAZ at the next edge, step_cnt=0, no step on that edge
   - without it -> LEFT finishes its remaining 2 steps, then HAZ

Source files
------------

// File: rtl/turn_signal_ctrl.sv
// Turn-signal arbitration and step-pulse sequencer in front of the tail-light FSM.
// Optional macro HAZ_PREEMPT_EN: a hazard request cuts a running LEFT/RIGHT sequence short.
module turn_signal_ctrl #(
  parameter int PRESCALE = 4,
  parameter int SEQ_LEN  = 4,
  parameter int CW       = $clog2(SEQ_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          left_req,
  input  logic          right_req,
  input  logic          haz_req,
  output logic          L,
  output logic          R,
  output logic          step,
  output logic          busy,
  output logic [CW-1:0] step_cnt
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZ} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          l_q, l_d, r_q, r_d, step_q, step_d, busy_q, busy_d;
  logic          preempt;

  // Both directions requested together is treated as a hazard request.
  function automatic state_t arbitrate(input logic h, input logic l, input logic r);
    if (h || (l && r)) return HAZ;
    else if (l)        return LEFT;
    else if (r)        return RIGHT;
    else               return IDLE;
  endfunction

  always_comb begin
`ifdef HAZ_PREEMPT_EN
    preempt = haz_req && ((state_q == LEFT) || (state_q == RIGHT));
`else
    preempt = 1'b0;
`endif
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      state_d = arbitrate(haz_req, left_req, right_req);
      presc_d = '0;
      cnt_d   = '0;
    end else if (preempt) begin
      state_d = HAZ;
      presc_d = '0;
      cnt_d   = '0;
    end else if (presc_q == PW'(PRESCALE - 1)) begin
      presc_d = '0;
      if (cnt_q == CW'(SEQ_LEN - 1)) begin
        cnt_d   = '0;
        state_d = arbitrate(haz_req, left_req, right_req);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end

    // Outputs are registered from the next state so they line up with the state register.
    l_d    = (state_d == LEFT)  || (state_d == HAZ);
    r_d    = (state_d == RIGHT) || (state_d == HAZ);
    busy_d = (state_d != IDLE);
    step_d = (state_d != IDLE) && (presc_d == PW'(PRESCALE - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      cnt_q   <= '0;
      l_q     <= 1'b0;
      r_q     <= 1'b0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
    end
  end

  assign L        = l_q;
  assign R        = r_q;
  assign step     = step_q;
  assign busy     = busy_q;
  assign step_cnt = cnt_q;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Directed scoreboard bench for turn_signal_ctrl (PRESCALE=4, SEQ_LEN=4).
// Build with +define+HAZ_PREEMPT_EN to exercise the preemption variant.
module tb_turn_signal_ctrl;

  logic       clk;
  logic       reset;
  logic       left_req, right_req, haz_req;
  logic       L, R, step, busy;
  logic [1:0] step_cnt;

  typedef struct {
    logic [5:0] vec;
    string      tag;
  } exp_t;

  exp_t sbQ[$];
  int   total = 0;
  int   bad   = 0;

  turn_signal_ctrl #(.PRESCALE(4), .SEQ_LEN(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .left_req (left_req),
    .right_req(right_req),
    .haz_req  (haz_req),
    .L        (L),
    .R        (R),
    .step     (step),
    .busy     (busy),
    .step_cnt (step_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic l, input logic r, input logic h);
    left_req  = l;
    right_req = r;
    haz_req   = h;
  endtask

  // Expected vector layout: {L, R, busy, step, step_cnt}
  task automatic pushSeqPart(input logic l, input logic r, input int k0, input int k1, input string tag);
    exp_t e;
    for (int k = k0; k <= k1; k++) begin
      e.vec = {l, r, 1'b1, (k % 4) == 0, 2'(((k - 1) / 4) % 4)};
      e.tag = $sformatf("%s_c%0d", tag, k);
      sbQ.push_back(e);
    end
  endtask

  task automatic pushSeq(input logic l, input logic r, input string tag);
    pushSeqPart(l, r, 1, 16, tag);
  endtask

  task automatic pushIdle(input int n, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.vec = 6'b000000;
      e.tag = $sformatf("%s_idle%0d", tag, i);
      sbQ.push_back(e);
    end
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [5:0] obs;
    @(posedge clk);
    #1;
    obs = {L, R, busy, step, step_cnt};
    total++;
    if (sbQ.size() == 0) begin
      bad++;
      $error("[TB] FAIL scoreboard_empty: observed=%b expected=queued_entry", obs);
    end else begin
      e = sbQ.pop_front();
      assert (obs === e.vec)
      else begin
        bad++;
        $error("[TB] FAIL %s: observed=%b expected=%b", e.tag, obs, e.vec);
      end
    end
  endtask

  task automatic runChecks(input int n);
    for (int i = 0; i < n; i++) checkOutput();
  endtask

  initial begin
    // 1: reset with all requests high, then release straight into HAZ
    reset = 1'b0;
    applyStimulus(1, 1, 1);
    pushIdle(2, "reset");
    runChecks(2);
    reset = 1'b1;
    pushSeq(1, 1, "rst_haz");
    checkOutput();
    applyStimulus(0, 0, 0);
    runChecks(15);
    pushIdle(2, "rst_haz");
    runChecks(2);

    // 2: single-cycle left pulse gives one full sequence
    applyStimulus(1, 0, 0);
    pushSeq(1, 0, "left_pulse");
    checkOutput();
    applyStimulus(0, 0, 0);
    runChecks(15);
    pushIdle(2, "left_pulse");
    runChecks(2);

    // 3: right held for 40 cycles gives three back-to-back sequences
    applyStimulus(0, 1, 0);
    pushSeq(0, 1, "right_a");
    pushSeq(0, 1, "right_b");
    pushSeq(0, 1, "right_c");
    runChecks(40);
    applyStimulus(0, 0, 0);
    runChecks(8);
    pushIdle(2, "right_hold");
    runChecks(2);

    // 4: opposite request locked out, then direct LEFT->RIGHT switch
    applyStimulus(1, 0, 0);
    pushSeq(1, 0, "lock_left");
    pushSeq(0, 1, "lock_right");
    checkOutput();
    applyStimulus(0, 0, 0);
    runChecks(4);
    applyStimulus(0, 1, 0);
    checkOutput();
    applyStimulus(0, 0, 0);
    runChecks(6);
    applyStimulus(0, 1, 0);
    runChecks(5);
    applyStimulus(0, 0, 0);
    runChecks(15);
    pushIdle(2, "lock");
    runChecks(2);

    // 5: left and right together in IDLE -> HAZ
    applyStimulus(1, 1, 0);
    pushSeq(1, 1, "both_haz");
    checkOutput();
    applyStimulus(0, 0, 0);
    runChecks(15);
    pushIdle(2, "both_haz");
    runChecks(2);

    // 6: hazard arriving mid-LEFT at step_cnt=2
    applyStimulus(1, 0, 0);
`ifdef HAZ_PREEMPT_EN
    pushSeqPart(1, 0, 1, 9, "pre_left");
`else
    pushSeq(1, 0, "pre_left");
`endif
    pushSeq(1, 1, "pre_haz");
    checkOutput();
    applyStimulus(0, 0, 0);
    runChecks(8);
    applyStimulus(0, 0, 1);
`ifdef HAZ_PREEMPT_EN
    checkOutput();
`else
    runChecks(8);
`endif
    applyStimulus(0, 0, 0);
    runChecks(15);
    pushIdle(2, "pre");
    runChecks(2);

    // 7: reset mid-sequence clears everything with no completion step
    applyStimulus(1, 0, 0);
    pushSeqPart(1, 0, 1, 6, "midrst_left");
    checkOutput();
    applyStimulus(0, 0, 0);
    runChecks(5);
    reset = 1'b0;
    pushIdle(1, "midrst");
    checkOutput();
    reset = 1'b1;
    pushIdle(2, "midrst_after");
    runChecks(2);

    total++;
    assert (sbQ.size() == 0)
    else begin
      bad++;
      $error("[TB] FAIL scoreboard_drain: observed=%0d expected=0", sbQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
